// File: rtl/bp_update_scheduler.sv
// Round-robin collector of resolved-branch outcomes feeding a FIFO that drains one
// update per cycle to the gshare predictor. Optional counters: define BP_SCHED_STATS_EN.
module bp_update_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1,
    localparam int RW = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_pc_i,
    input  logic [NUM_REQ-1:0]    req_taken_i,
    input  logic [NUM_REQ*32-1:0] req_target_i,
    input  logic [NUM_REQ-1:0]    req_pred_taken_i,
    input  logic [NUM_REQ*32-1:0] req_pred_target_i,
    input  logic                  hold_i,
    output logic                  update_en_o,
    output logic [31:0]           update_pc_o,
    output logic                  actual_taken_o,
    output logic [31:0]           actual_target_o,
    output logic [CW-1:0]         fifo_count_o
`ifdef BP_SCHED_STATS_EN
    ,
    output logic [31:0]           stat_updates_o,
    output logic [31:0]           stat_mispred_o
`endif
);

    logic [31:0]         r_pc_mem  [FIFO_DEPTH];
    logic [31:0]         r_tgt_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_taken_mem;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [RW-1:0]       r_rr_ptr;

    logic [31:0]         w_pc_arr  [NUM_REQ];
    logic [31:0]         w_tgt_arr [NUM_REQ];
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_gnt_vld;
    logic [RW-1:0]       w_gnt_idx;
    logic [RW-1:0]       w_rr_next;
    logic [NUM_REQ-1:0]  w_ready;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_pc_arr[g]  = req_pc_i[32*g +: 32];
        assign w_tgt_arr[g] = req_target_i[32*g +: 32];
    end

    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_pop  = (r_count != '0) && !hold_i;

    // Scan from the round-robin pointer; a full queue refuses even when popping.
    always_comb begin
        logic [RW-1:0] idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_ready   = '0;
        idx       = '0;
        if (reset_ni && !w_full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = RW'((int'(r_rr_ptr) + k) % NUM_REQ);
                if (!w_gnt_vld && req_valid_i[idx]) begin
                    w_gnt_vld    = 1'b1;
                    w_gnt_idx    = idx;
                    w_ready[idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready_o  = w_ready;
    assign w_push       = w_gnt_vld;
    assign w_rr_next    = (w_gnt_idx == RW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign fifo_count_o = r_count;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= w_pc_arr[w_gnt_idx];
            r_tgt_mem[r_wr_ptr]   <= w_tgt_arr[w_gnt_idx];
            r_taken_mem[r_wr_ptr] <= req_taken_i[w_gnt_idx];
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_rr_ptr        <= '0;
            update_en_o     <= 1'b0;
            update_pc_o     <= '0;
            actual_taken_o  <= 1'b0;
            actual_target_o <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= w_rr_next;
            end
            if (w_pop) begin
                r_rd_ptr        <= r_rd_ptr + 1'b1;
                update_pc_o     <= r_pc_mem[r_rd_ptr];
                actual_taken_o  <= r_taken_mem[r_rd_ptr];
                actual_target_o <= r_tgt_mem[r_rd_ptr];
            end
            update_en_o <= w_pop;
            r_count     <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef BP_SCHED_STATS_EN
    logic [31:0]           w_ptgt_arr [NUM_REQ];
    logic [FIFO_DEPTH-1:0] r_misp_mem;
    logic                  w_misp;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack_pred
        assign w_ptgt_arr[g] = req_pred_target_i[32*g +: 32];
    end

    assign w_misp = (req_pred_taken_i[w_gnt_idx] != req_taken_i[w_gnt_idx]) |
                    (req_taken_i[w_gnt_idx] & (w_ptgt_arr[w_gnt_idx] != w_tgt_arr[w_gnt_idx]));

    always_ff @(posedge clk_i) begin
        if (w_push) r_misp_mem[r_wr_ptr] <= w_misp;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stat_updates_o <= '0;
            stat_mispred_o <= '0;
        end else if (w_pop) begin
            stat_updates_o <= stat_updates_o + 32'd1;
            if (r_misp_mem[r_rd_ptr]) stat_mispred_o <= stat_mispred_o + 32'd1;
        end
    end
`else
    // Prediction inputs only feed the optional counters.
    logic w_unused_pred;
    assign w_unused_pred = ^{req_pred_taken_i, req_pred_target_i};
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler: per-cycle vector table plus hand sequences
// for asynchronous reset and (when BP_SCHED_STATS_EN is defined) the counters.
module tb_bp_update_scheduler;

    logic        clk;
    logic        reset_ni;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_pc;
    logic [1:0]  req_taken;
    logic [63:0] req_target;
    logic [1:0]  req_pred_taken;
    logic [63:0] req_pred_target;
    logic        hold;
    logic        update_en;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic [31:0] actual_target;
    logic [2:0]  fifo_count;
`ifdef BP_SCHED_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispred;
`endif

    int total = 0;
    int bad   = 0;

    bp_update_scheduler #(.NUM_REQ(2), .FIFO_DEPTH(4)) dut (
        .clk_i             (clk),
        .reset_ni          (reset_ni),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_pc_i          (req_pc),
        .req_taken_i       (req_taken),
        .req_target_i      (req_target),
        .req_pred_taken_i  (req_pred_taken),
        .req_pred_target_i (req_pred_target),
        .hold_i            (hold),
        .update_en_o       (update_en),
        .update_pc_o       (update_pc),
        .actual_taken_o    (actual_taken),
        .actual_target_o   (actual_target),
        .fifo_count_o      (fifo_count)
`ifdef BP_SCHED_STATS_EN
        ,
        .stat_updates_o    (stat_updates),
        .stat_mispred_o    (stat_mispred)
`endif
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic        hold;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  taken;
        logic [1:0]  exp_ready;
        logic [2:0]  exp_count;
        logic        exp_en;
        logic [31:0] exp_pc;
        logic        exp_taken;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] v, input logic h,
                       input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] tk,
                       input logic [1:0] er, input logic [2:0] ec, input logic een,
                       input logic [31:0] epc, input logic etk);
        vec_t r;
        r.rst = rst; r.valid = v; r.hold = h; r.pc0 = p0; r.pc1 = p1; r.taken = tk;
        r.exp_ready = er; r.exp_count = ec; r.exp_en = een; r.exp_pc = epc; r.exp_taken = etk;
        vecs.push_back(r);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
        end
    endtask

    // driver tasks; targets are pc+0x100 and predictions match actuals by default
    task automatic drive(input logic [1:0] v, input logic h, input logic [31:0] p0,
                         input logic [31:0] p1, input logic [1:0] tk);
        req_valid       = v;
        hold            = h;
        req_pc          = {p1, p0};
        req_target      = {p1 + 32'h100, p0 + 32'h100};
        req_taken       = tk;
        req_pred_taken  = tk;
        req_pred_target = {p1 + 32'h100, p0 + 32'h100};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        reset_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_ni = 1'b1;
        tick();
    endtask

    initial begin
        drive(2'b01, 1'b0, 32'hAAAA, 32'h0, 2'b00);
        reset_ni = 1'b1;
        #1;
        reset_ni = 1'b0;
        #1;
        chk("rst_ready", -1, 32'(req_ready), 32'h0);
        chk("rst_count", -1, 32'(fifo_count), 32'h0);
        chk("rst_en",    -1, 32'(update_en), 32'h0);
        chk("rst_pc",    -1, update_pc, 32'h0);
        chk("rst_taken", -1, 32'(actual_taken), 32'h0);
        chk("rst_tgt",   -1, actual_target, 32'h0);
        do_reset();

        // single accept, two-edge latency
        add(1, 2'b01, 0, 32'h100,  32'h0,    2'b01, 2'b01, 1, 0, 32'h0,    0);
        add(0, 2'b00, 0, 32'h0,    32'h0,    2'b00, 2'b00, 0, 1, 32'h100,  1);
        add(0, 2'b00, 0, 32'h0,    32'h0,    2'b00, 2'b00, 0, 0, 32'h0,    0);
        // both valid under hold: grants 0,1,0,1 then full
        add(1, 2'b11, 1, 32'h1000, 32'h2000, 2'b01, 2'b01, 1, 0, 32'h0,    0);
        add(0, 2'b11, 1, 32'h1000, 32'h2000, 2'b01, 2'b10, 2, 0, 32'h0,    0);
        add(0, 2'b11, 1, 32'h1004, 32'h2004, 2'b01, 2'b01, 3, 0, 32'h0,    0);
        add(0, 2'b11, 1, 32'h1008, 32'h2004, 2'b01, 2'b10, 4, 0, 32'h0,    0);
        add(0, 2'b11, 1, 32'h1008, 32'h2008, 2'b01, 2'b00, 4, 0, 32'h0,    0);
        // full with pop: no accept, then accept next cycle (4->3->4)
        add(0, 2'b11, 0, 32'h1008, 32'h2008, 2'b01, 2'b00, 3, 1, 32'h1000, 1);
        add(0, 2'b11, 1, 32'h1008, 32'h2008, 2'b01, 2'b01, 4, 0, 32'h0,    0);
        // drain in acceptance order
        add(0, 2'b00, 0, 32'h0,    32'h0,    2'b00, 2'b00, 3, 1, 32'h2000, 0);
        add(0, 2'b00, 0, 32'h0,    32'h0,    2'b00, 2'b00, 2, 1, 32'h1004, 1);
        add(0, 2'b00, 0, 32'h0,    32'h0,    2'b00, 2'b00, 1, 1, 32'h2004, 0);
        add(0, 2'b00, 0, 32'h0,    32'h0,    2'b00, 2'b00, 0, 1, 32'h1008, 1);
        add(0, 2'b00, 0, 32'h0,    32'h0,    2'b00, 2'b00, 0, 0, 32'h0,    0);
        // steady enqueue+dequeue from requester 1
        add(0, 2'b10, 0, 32'h0,    32'h3000, 2'b10, 2'b10, 1, 0, 32'h0,    0);
        add(0, 2'b10, 0, 32'h0,    32'h3004, 2'b10, 2'b10, 1, 1, 32'h3000, 1);
        add(0, 2'b10, 0, 32'h0,    32'h3008, 2'b10, 2'b10, 1, 1, 32'h3004, 1);
        add(0, 2'b00, 0, 32'h0,    32'h0,    2'b00, 2'b00, 0, 1, 32'h3008, 1);
        add(0, 2'b00, 0, 32'h0,    32'h0,    2'b00, 2'b00, 0, 0, 32'h0,    0);
        // round-robin resumes at requester 0 after a grant to 1
        add(0, 2'b11, 0, 32'h4000, 32'h5000, 2'b11, 2'b01, 1, 0, 32'h0,    0);
        add(0, 2'b11, 0, 32'h4004, 32'h5000, 2'b11, 2'b10, 1, 1, 32'h4000, 1);
        add(0, 2'b00, 0, 32'h0,    32'h0,    2'b00, 2'b00, 0, 1, 32'h5000, 1);
        add(0, 2'b00, 0, 32'h0,    32'h0,    2'b00, 2'b00, 0, 0, 32'h0,    0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].valid, vecs[i].hold, vecs[i].pc0, vecs[i].pc1, vecs[i].taken);
            #1;
            chk("ready", i, 32'(req_ready), 32'(vecs[i].exp_ready));
            tick();
            chk("count", i, 32'(fifo_count), 32'(vecs[i].exp_count));
            chk("update_en", i, 32'(update_en), 32'(vecs[i].exp_en));
            if (vecs[i].exp_en) begin
                chk("update_pc", i, update_pc, vecs[i].exp_pc);
                chk("actual_taken", i, 32'(actual_taken), 32'(vecs[i].exp_taken));
                chk("actual_target", i, actual_target, vecs[i].exp_pc + 32'h100);
            end
        end

        // asynchronous reset with entries queued and an update in flight
        drive(2'b01, 1'b1, 32'h6000, 32'h0, 2'b01); tick();
        drive(2'b01, 1'b1, 32'h6004, 32'h0, 2'b01); tick();
        drive(2'b01, 1'b1, 32'h6008, 32'h0, 2'b01); tick();
        chk("ar_count3", 100, 32'(fifo_count), 32'h3);
        drive(2'b00, 1'b0, 32'h0, 32'h0, 2'b00); tick();
        chk("ar_en_pre", 101, 32'(update_en), 32'h1);
        chk("ar_count2", 101, 32'(fifo_count), 32'h2);
        drive(2'b01, 1'b0, 32'h600C, 32'h0, 2'b01);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("ar_en", 102, 32'(update_en), 32'h0);
        chk("ar_count", 102, 32'(fifo_count), 32'h0);
        chk("ar_ready", 102, 32'(req_ready), 32'h0);
        chk("ar_pc", 102, update_pc, 32'h0);
        drive(2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("ar_no_stale_en", 103 + c, 32'(update_en), 32'h0);
            chk("ar_no_stale_cnt", 103 + c, 32'(fifo_count), 32'h0);
        end

`ifdef BP_SCHED_STATS_EN
        do_reset();
        chk("stat_upd_rst", 200, stat_updates, 32'h0);
        chk("stat_misp_rst", 200, stat_mispred, 32'h0);
        drive(2'b01, 1'b1, 32'h7000, 32'h0, 2'b01);
        req_pred_taken = 2'b01; req_pred_target = {32'h0, 32'h7100};
        tick();
        drive(2'b01, 1'b1, 32'h7004, 32'h0, 2'b01);
        req_pred_taken = 2'b00; req_pred_target = {32'h0, 32'h7104};
        tick();
        drive(2'b01, 1'b1, 32'h7008, 32'h0, 2'b01);
        req_pred_taken = 2'b01; req_pred_target = {32'h0, 32'h9999};
        tick();
        drive(2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        repeat (4) tick();
        chk("stat_updates", 201, stat_updates, 32'd3);
        chk("stat_mispred", 201, stat_mispred, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
